alu_ctrl_decode_q: RTL and testbench

- Registered, queued successor to the single-cycle ALU/datapath control decoder.
- Accepts one instruction opcode per cycle over a valid/ready handshake and decodes it into a control word.
- Buffers control words, with a caller-supplied tag, in a DEPTH-entry FIFO toward the execute stage.
- Adds three things the single-cycle decoder lacks: back-pressure, pipeline flush, and a sticky halt state machine with resume.

---
 rtl/alu_ctrl_decode_q.sv | 111 +++++++++++
 tb/tb_alu_ctrl_decode_q.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_decode_q.sv
// Queued ALU/datapath control decoder: valid/ready intake, DEPTH-entry control-word FIFO, flush, sticky halt FSM.
// Optional macro ALU_CTRL_ILLEGAL_TRAP_EN: illegal opcodes also set halt and stop intake like a halt word.
module alu_ctrl_decode_q #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_opcode,
  input  logic [1:0]               in_op_ext,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_ctrl,
  output logic [TAG_W-1:0]         out_tag,
  input  logic                     flush,
  input  logic                     resume,
  output logic                     halted,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {RUN, HALTED} state_t;

  state_t           state_q;
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic [15:0]      ctrl_mem [DEPTH];
  logic [TAG_W-1:0] tag_mem  [DEPTH];

  logic        push, pop;
  logic [15:0] dec_word;

  function automatic logic [15:0] decode(input logic [4:0] op, input logic [1:0] ext);
    logic [15:0] w;
    w = '0;
    casez (op)
      5'b00000: w[15] = 1'b1;
      5'b00001: w = '0;
      5'b001??: w[11] = 1'b1;
      5'b011??: begin w[10] = 1'b1; w[9:8] = op[1:0]; end
      5'b10000: begin w[13] = 1'b1; w[1] = 1'b1; end
      5'b10001: begin w[14] = 1'b1; w[12] = 1'b1; w[1] = 1'b1; end
      5'b010??: begin w[14] = 1'b1; w[1] = 1'b1; w[7:5] = {1'b0, op[1:0]}; end
      5'b11011: begin w[14] = 1'b1; w[7:5] = {1'b1, ext}; end
      5'b11001: begin
        w[14] = 1'b1;
        case (ext)
          2'b01:   begin w[4] = 1'b1; w[2] = 1'b1; end
          2'b10:   w[7:5] = 3'b011;
          2'b11:   begin w[7:5] = 3'b001; w[3] = 1'b1; end
          default: w[7:5] = 3'b000;
        endcase
      end
      default: begin
        w[0] = 1'b1;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
        w[15] = 1'b1;
`endif
      end
    endcase
    return w;
  endfunction

  always_comb begin
    dec_word  = decode(in_opcode, in_op_ext);
    out_valid = (count_q != '0);
    pop       = out_valid & out_ready;
    // A same-cycle pop frees a slot, so a full queue can still accept.
    in_ready  = ~rst & ~flush & (state_q == RUN) & ((count_q != DEPTH_C) | pop);
    push      = in_valid & in_ready;
    out_ctrl  = out_valid ? ctrl_mem[rptr_q] : '0;
    out_tag   = out_valid ? tag_mem[rptr_q]  : '0;
    halted    = (state_q == HALTED);
    count     = count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (flush) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        count_q <= '0;
      end else begin
        if (push) begin
          ctrl_mem[wptr_q] <= dec_word;
          tag_mem[wptr_q]  <= in_tag;
          wptr_q           <= wptr_q + PW'(1);
        end
        if (pop) rptr_q <= rptr_q + PW'(1);
        count_q <= count_q + CW'(push) - CW'(pop);
      end
      case (state_q)
        RUN:     if (push && dec_word[15]) state_q <= HALTED;
        HALTED:  if (resume) state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_decode_q.sv
// Directed bench for alu_ctrl_decode_q: decode sweep table plus back-pressure, halt, flush and reset sequences.
module tb_alu_ctrl_decode_q;
  localparam int DEPTH = 4;
  localparam int TAG_W = 16;

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  localparam logic [15:0] ILL = 16'h8001;
`else
  localparam logic [15:0] ILL = 16'h0001;
`endif

  localparam logic [15:0] EXP_OP [32] = '{
    16'h8000, 16'h0000, ILL, ILL,
    16'h0800, 16'h0800, 16'h0800, 16'h0800,
    16'h4002, 16'h4022, 16'h4042, 16'h4062,
    16'h0400, 16'h0500, 16'h0600, 16'h0700,
    16'h2002, 16'h5002, ILL, ILL, ILL, ILL, ILL, ILL, ILL,
    16'h4000, ILL, 16'h4080, ILL, ILL, ILL, ILL};
  localparam logic [15:0] EXP_RT [4] = '{16'h4080, 16'h40A0, 16'h40C0, 16'h40E0};
  localparam logic [15:0] EXP_AR [4] = '{16'h4000, 16'h4014, 16'h4060, 16'h4028};

  typedef struct {
    logic [4:0]  op;
    logic [1:0]  ext;
    logic [15:0] exp;
  } vec_t;

  logic             clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [4:0]       in_opcode;
  logic [1:0]       in_op_ext;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic [15:0]      out_ctrl;
  logic             flush, resume, halted;
  logic [2:0]       count;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs [128];

  alu_ctrl_decode_q #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_op_ext(in_op_ext), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_tag(out_tag),
    .flush(flush), .resume(resume), .halted(halted), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [4:0] op, input logic [1:0] ext, input logic [15:0] tag);
    in_valid = 1'b1; in_opcode = op; in_op_ext = ext; in_tag = tag;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      vecs[i].op  = 5'(i >> 2);
      vecs[i].ext = 2'(i & 3);
      if (vecs[i].op == 5'd27)      vecs[i].exp = EXP_RT[vecs[i].ext];
      else if (vecs[i].op == 5'd25) vecs[i].exp = EXP_AR[vecs[i].ext];
      else                          vecs[i].exp = EXP_OP[vecs[i].op];
    end

    rst = 1'b1; in_valid = 1'b0; in_opcode = '0; in_op_ext = '0; in_tag = '0;
    out_ready = 1'b0; flush = 1'b0; resume = 1'b0;
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_out_ctrl", 32'(out_ctrl), 0);
    rst = 1'b0; #1;
    chk("post_rst_in_ready", 32'(in_ready), 1);

    // decode sweep
    for (int i = 0; i < 128; i++) begin
      in_valid = 1'b1; in_opcode = vecs[i].op; in_op_ext = vecs[i].ext;
      in_tag = 16'(16'h1000 + i); out_ready = 1'b0;
      #1;
      chk($sformatf("sweep_in_ready[%0d]", i), 32'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      chk($sformatf("sweep_ctrl[%0d]", i), 32'(out_ctrl), 32'(vecs[i].exp));
      chk($sformatf("sweep_tag[%0d]", i), 32'(out_tag), 32'(16'h1000 + i));
      chk($sformatf("sweep_halted[%0d]", i), 32'(halted), 32'(vecs[i].exp[15]));
      out_ready = 1'b1; resume = 1'b1;
      tick();
      out_ready = 1'b0; resume = 1'b0;
      chk($sformatf("sweep_drain[%0d]", i), {29'd0, count} | {31'd0, halted} << 8, 0);
    end

    // back-pressure
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_opcode = 5'b11001; in_op_ext = 2'b00; in_tag = 16'(100 + k);
      #1;
      chk($sformatf("bp_in_ready[%0d]", k), 32'(in_ready), 32'(k < 4));
      tick();
    end
    in_valid = 1'b0;
    chk("bp_full_count", 32'(count), 4);
    chk("bp_head_tag", 32'(out_tag), 100);
    in_valid = 1'b1; in_tag = 16'd104; out_ready = 1'b1;
    #1;
    chk("bp_pushpop_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("bp_pushpop_count", 32'(count), 4);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp_order[%0d]", k), 32'(out_tag), 32'(101 + k));
      tick();
    end
    out_ready = 1'b0;
    chk("bp_empty_valid", 32'(out_valid), 0);
    chk("bp_empty_ctrl", 32'(out_ctrl), 0);
    chk("bp_empty_tag", 32'(out_tag), 0);

    // halt and resume
    push_word(5'b11001, 2'b00, 16'd1);
    push_word(5'b00000, 2'b00, 16'd2);
    chk("halt_halted", 32'(halted), 1);
    in_valid = 1'b1; in_opcode = 5'b11001; in_op_ext = 2'b00; in_tag = 16'd3;
    #1;
    chk("halt_in_ready", 32'(in_ready), 0);
    tick(); tick();
    chk("halt_stall_count", 32'(count), 2);
    out_ready = 1'b1;
    chk("halt_drain0_ctrl", 32'(out_ctrl), 32'h4000);
    chk("halt_drain0_tag", 32'(out_tag), 1);
    tick();
    chk("halt_drain1_ctrl", 32'(out_ctrl), 32'h8000);
    chk("halt_drain1_tag", 32'(out_tag), 2);
    tick();
    out_ready = 1'b0;
    chk("halt_drained_count", 32'(count), 0);
    chk("halt_still_halted", 32'(halted), 1);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("resume_halted", 32'(halted), 0);
    chk("resume_in_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    chk("resume_accept_count", 32'(count), 1);
    chk("resume_accept_tag", 32'(out_tag), 3);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // flush while halted
    push_word(5'b11001, 2'b00, 16'd10);
    push_word(5'b11001, 2'b01, 16'd11);
    push_word(5'b00000, 2'b00, 16'd12);
    chk("flush_pre_count", 32'(count), 3);
    in_valid = 1'b1; in_tag = 16'd13; flush = 1'b1;
    #1;
    chk("flush_in_ready", 32'(in_ready), 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_count", 32'(count), 0);
    chk("flush_out_valid", 32'(out_valid), 0);
    chk("flush_keeps_halted", 32'(halted), 1);

    // flush in RUN blocks the same-cycle push and rewinds pointers
    resume = 1'b1; tick(); resume = 1'b0;
    push_word(5'b10001, 2'b00, 16'd20);
    push_word(5'b10000, 2'b00, 16'd21);
    in_valid = 1'b1; in_tag = 16'd22; flush = 1'b1;
    #1;
    chk("flush_run_in_ready", 32'(in_ready), 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_run_count", 32'(count), 0);
    push_word(5'b10001, 2'b00, 16'd30);
    chk("flush_refill_count", 32'(count), 1);
    chk("flush_refill_tag", 32'(out_tag), 30);
    chk("flush_refill_ctrl", 32'(out_ctrl), 32'h5002);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // reset mid-stream while halted
    push_word(5'b11001, 2'b00, 16'd40);
    push_word(5'b00000, 2'b00, 16'd41);
    chk("mrst_pre_count", 32'(count), 2);
    chk("mrst_pre_halted", 32'(halted), 1);
    rst = 1'b1; in_valid = 1'b1; in_tag = 16'd42;
    #1;
    chk("mrst_in_ready", 32'(in_ready), 0);
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("mrst_count", 32'(count), 0);
    chk("mrst_out_valid", 32'(out_valid), 0);
    chk("mrst_halted", 32'(halted), 0);
    chk("mrst_out_ctrl", 32'(out_ctrl), 0);
    #1;
    chk("mrst_in_ready_after", 32'(in_ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
